tt_sel_engine: RTL

//  Next-generation user-module selection engine for the Tiny Tapeout mux fabric.
//  - Turns the three async control pads (sel_rst_n, sel_inc, ena) into a stable {branch, um} address plus a gated enable.
//  - Outputs drive the spine; grid size is parametrised.
//  - Adds features the current fixed controller lacks: sync stages, inc debounce, address settle guard, wrap-around, and a sticky "address valid" flag.

---
 rtl/tt_pkg.sv | 17 +
 rtl/tt_sync_deb.sv | 61 ++++++
 rtl/tt_sel_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared types and default grid geometry for the Tiny Tapeout user-module selection engine.
package tt_pkg;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_SETTLE = 2'd1,
        S_ACTIVE = 2'd2
    } sel_state_t;

    localparam int G_X_DEF  = 16;
    localparam int G_Y_DEF  = 24;
    localparam int BR_W_DEF = 5;

    localparam int N_UM_TOT = G_X_DEF * G_Y_DEF;
    localparam int UM_W     = $clog2(G_X_DEF);

endpackage

// File: rtl/tt_sync_deb.sv
// Pad conditioner: a SYNC_STAGES-deep synchroniser followed, when FILTER is set, by a
// level debouncer that accepts a change only after DEB_CYC consecutive disagreeing cycles.
module tt_sync_deb
    import tt_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 4,
    parameter bit FILTER      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level
);

    localparam bit USE_FILTER = FILTER && (DEB_CYC >= 1);

    logic [SYNC_STAGES-1:0] chain;
    logic                   synced;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pad};
        end
    end

    assign synced = chain[SYNC_STAGES-1];

    generate
        if (USE_FILTER) begin : g_deb
            localparam int            DW     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
            localparam logic [DW-1:0] D_LAST = DW'(DEB_CYC - 1);

            logic [DW-1:0] run;
            logic          filt;

            // Any cycle of agreement restarts the disagreement run.
            always_ff @(posedge clk) begin
                if (rst) begin
                    run  <= '0;
                    filt <= 1'b0;
                end else if (synced == filt) begin
                    run <= '0;
                end else if (run == D_LAST) begin
                    filt <= synced;
                    run  <= '0;
                end else begin
                    run <= run + 1'b1;
                end
            end

            assign level = filt;
        end else begin : g_pass
            assign level = synced;
        end
    endgenerate

endmodule

// File: rtl/tt_sel_engine.sv
// User-module selection engine: turns the conditioned control pads into a settled
// {branch, um} address, a sticky valid flag and a gated enable for the mux spine.
module tt_sel_engine
    import tt_pkg::*;
#(
    parameter int G_X         = G_X_DEF,
    parameter int G_Y         = G_Y_DEF,
    parameter int BR_W        = BR_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 4,
    parameter int SETTLE_CYC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pad_sel_rst_n,
    input  logic                    pad_sel_inc,
    input  logic                    pad_ena,
    output logic [BR_W-1:0]         sel_branch,
    output logic [$clog2(G_X)-1:0]  sel_um,
    output logic                    sel_ena,
    output logic                    sel_valid
);

    localparam int N_TOT = G_X * G_Y;
    localparam int UMW   = $clog2(G_X);
    localparam int CNT_W = $clog2(N_TOT);
    localparam int STL_W = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TOT - 1);
    localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYC - 1);

    logic rst_s;
    logic inc_f;
    logic ena_s;
    logic inc_f_q;
    logic inc_evt;

    sel_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [STL_W-1:0] stl, stl_n;
    logic             ena_n;
    logic             valid_n;

    // Reset and enable pads only need synchronising; the increment pad is also debounced.
    tt_sync_deb #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYC     (1),
        .FILTER      (1'b0)
    ) u_rst_pad (
        .clk   (clk),
        .rst   (rst),
        .pad   (pad_sel_rst_n),
        .level (rst_s)
    );

    tt_sync_deb #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYC     (DEB_CYC),
        .FILTER      (1'b1)
    ) u_inc_pad (
        .clk   (clk),
        .rst   (rst),
        .pad   (pad_sel_inc),
        .level (inc_f)
    );

    tt_sync_deb #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYC     (1),
        .FILTER      (1'b0)
    ) u_ena_pad (
        .clk   (clk),
        .rst   (rst),
        .pad   (pad_ena),
        .level (ena_s)
    );

    assign inc_evt = inc_f & ~inc_f_q;
    assign cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RESET;
            cnt       <= '0;
            stl       <= '0;
            sel_ena   <= 1'b0;
            sel_valid <= 1'b0;
            inc_f_q   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            stl       <= stl_n;
            sel_ena   <= ena_n;
            sel_valid <= valid_n;
            inc_f_q   <= inc_f;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stl_n   = stl;
        ena_n   = 1'b0;
        valid_n = 1'b0;

        if (!rst_s) begin
            // Selection reset wins over a coincident increment.
            state_n = S_RESET;
            cnt_n   = '0;
            stl_n   = '0;
        end else begin
            unique case (state)
                S_RESET: begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                    stl_n   = '0;
                end
                S_SETTLE: begin
                    if (inc_evt) begin
                        cnt_n = cnt_inc;
                        stl_n = '0;
                    end else if (stl == STL_LAST) begin
                        state_n = S_ACTIVE;
                        stl_n   = '0;
                        valid_n = 1'b1;
                    end else begin
                        stl_n = stl + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (inc_evt) begin
                        state_n = S_SETTLE;
                        cnt_n   = cnt_inc;
                        stl_n   = '0;
                    end else begin
                        valid_n = 1'b1;
                        ena_n   = ena_s;
                    end
                end
                default: begin
                    state_n = S_RESET;
                    cnt_n   = '0;
                    stl_n   = '0;
                end
            endcase
        end
    end

    assign sel_um     = cnt[UMW-1:0];
    assign sel_branch = BR_W'(cnt >> UMW);

endmodule
